// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer: merges load-use, branch, mult/div and dmem-wait into per-stage enables/flushes.
// Enables/flushes are combinational from state+inputs; state, mdTimer, stallCycles, mdTimeout are registered.
module pipe_stall_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hazardFlag,
  input  logic             branchTaken,
  input  logic             mdStart,
  input  logic             mdDone,
  input  logic             memReq,
  input  logic             memReady,
  input  logic             statClr,
  output logic             pcWrite,
  output logic             ifidWrite,
  output logic             idexWrite,
  output logic             exmemWrite,
  output logic             memwbWrite,
  output logic             ifidFlush,
  output logic             idexFlush,
  output logic             exmemFlush,
  output logic             mdTimeout,
  output logic [CNT_W-1:0] stallCycles,
  output logic [1:0]       ctrlState
);

  localparam int TW = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(MD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    MDWAIT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    md_timer_q, md_timer_d;
  logic             md_timeout_q, md_timeout_d;
  logic [CNT_W-1:0] stall_cnt_q;

  logic mem_stall;
  logic eval_rules;
  logic allow_md;

  assign mem_stall   = memReq & ~memReady;
  assign ctrlState   = state_q;
  assign mdTimeout   = md_timeout_q;
  assign stallCycles = stall_cnt_q;

  always_comb begin
    state_d      = state_q;
    md_timer_d   = md_timer_q;
    md_timeout_d = 1'b0;
    eval_rules   = 1'b0;
    allow_md     = 1'b0;
    pcWrite      = 1'b1;
    ifidWrite    = 1'b1;
    idexWrite    = 1'b1;
    exmemWrite   = 1'b1;
    memwbWrite   = 1'b1;
    ifidFlush    = 1'b0;
    idexFlush    = 1'b0;
    exmemFlush   = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_stall) begin
          {pcWrite, ifidWrite, idexWrite, exmemWrite, memwbWrite} = '0;
          state_d = MEMWAIT;
        end else begin
          eval_rules = 1'b1;
          allow_md   = 1'b1;
        end
      end
      MEMWAIT: begin
        if (!memReady) begin
          {pcWrite, ifidWrite, idexWrite, exmemWrite, memwbWrite} = '0;
        end else begin
          state_d    = RUN;
          eval_rules = 1'b1;
          allow_md   = 1'b1;
        end
      end
      MDWAIT: begin
        if (mem_stall) begin
          {pcWrite, ifidWrite, idexWrite, exmemWrite, memwbWrite} = '0;
        end else if (mdDone || md_timer_q == TMR_LAST) begin
          // Release cycle: EX result is captured; a timeout is reported one cycle later
          state_d      = RUN;
          eval_rules   = 1'b1;
          md_timeout_d = ~mdDone;
        end else begin
          {pcWrite, ifidWrite, idexWrite} = '0;
          exmemFlush = 1'b1;
          md_timer_d = md_timer_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    if (eval_rules) begin
      if (branchTaken) begin
        ifidFlush = 1'b1;
        idexFlush = 1'b1;
      end else if (allow_md && mdStart) begin
        {pcWrite, ifidWrite, idexWrite} = '0;
        exmemFlush = 1'b1;
        state_d    = MDWAIT;
        md_timer_d = '0;
      end else if (hazardFlag) begin
        pcWrite   = 1'b0;
        ifidWrite = 1'b0;
        idexFlush = 1'b1;
      end
    end

    // Hold every latch while reset is asserted, even mid-cycle
    if (!rst_n) begin
      {pcWrite, ifidWrite, idexWrite, exmemWrite, memwbWrite} = '0;
      {ifidFlush, idexFlush, exmemFlush} = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      md_timer_q   <= '0;
      md_timeout_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      md_timer_q   <= md_timer_d;
      md_timeout_q <= md_timeout_d;
      if (statClr) begin
        stall_cnt_q <= '0;
      end else if (!pcWrite && stall_cnt_q != '1) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl (MD_TIMEOUT=8, CNT_W=4); inputs change 1ns after the rising edge.
module tb_pipe_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hazardFlag, branchTaken, mdStart, mdDone, memReq, memReady, statClr;
  logic       pcWrite, ifidWrite, idexWrite, exmemWrite, memwbWrite;
  logic       ifidFlush, idexFlush, exmemFlush, mdTimeout;
  logic [3:0] stallCycles;
  logic [1:0] ctrlState;
  logic [4:0] wr_v;
  logic [2:0] fl_v;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign wr_v = {pcWrite, ifidWrite, idexWrite, exmemWrite, memwbWrite};
  assign fl_v = {ifidFlush, idexFlush, exmemFlush};

  pipe_stall_ctrl #(.MD_TIMEOUT(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .hazardFlag(hazardFlag), .branchTaken(branchTaken),
    .mdStart(mdStart), .mdDone(mdDone),
    .memReq(memReq), .memReady(memReady), .statClr(statClr),
    .pcWrite(pcWrite), .ifidWrite(ifidWrite), .idexWrite(idexWrite),
    .exmemWrite(exmemWrite), .memwbWrite(memwbWrite),
    .ifidFlush(ifidFlush), .idexFlush(idexFlush), .exmemFlush(exmemFlush),
    .mdTimeout(mdTimeout), .stallCycles(stallCycles), .ctrlState(ctrlState)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    statClr = 1'b1;
    tick();
    statClr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    {hazardFlag, branchTaken, mdStart, mdDone, memReq, memReady, statClr} = '0;
    #12;
    check("rst_wr", wr_v, 5'b00000);
    check("rst_fl", fl_v, 3'b000);
    check("rst_state", ctrlState, 2'd0);
    check("rst_cnt", stallCycles, 4'd0);
    check("rst_tmo", mdTimeout, 1'b0);
    rst_n = 1'b1;
    tick();
    check("idle_wr", wr_v, 5'b11111);
    check("idle_cnt", stallCycles, 4'd0);

    // T1 load-use bubble
    hazardFlag = 1'b1; #1;
    check("t1_wr", wr_v, 5'b00111);
    check("t1_fl", fl_v, 3'b010);
    tick();
    hazardFlag = 1'b0; #1;
    check("t1_wr_after", wr_v, 5'b11111);
    check("t1_fl_after", fl_v, 3'b000);
    check("t1_cnt", stallCycles, 4'd1);

    // T2 three-cycle dmem wait
    clear_stats();
    memReq = 1'b1; memReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t2_wr_wait", wr_v, 5'b00000);
      tick();
      check("t2_state", ctrlState, 2'd1);
    end
    memReady = 1'b1; #1;
    check("t2_wr_rel", wr_v, 5'b11111);
    tick();
    memReq = 1'b0; memReady = 1'b0; #1;
    check("t2_state_run", ctrlState, 2'd0);
    check("t2_cnt", stallCycles, 4'd3);

    // T3 mult/div with mdDone on the 6th MDWAIT cycle
    clear_stats();
    mdStart = 1'b1; #1;
    check("t3_wr_start", wr_v, 5'b00011);
    check("t3_fl_start", fl_v, 3'b001);
    tick();
    mdStart = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t3_state", ctrlState, 2'd2);
      check("t3_wr_wait", wr_v, 5'b00011);
      check("t3_fl_wait", fl_v, 3'b001);
      tick();
    end
    mdDone = 1'b1; #1;
    check("t3_state_done", ctrlState, 2'd2);
    check("t3_wr_done", wr_v, 5'b11111);
    check("t3_fl_done", fl_v, 3'b000);
    tick();
    mdDone = 1'b0; #1;
    check("t3_state_run", ctrlState, 2'd0);
    check("t3_cnt", stallCycles, 4'd6);
    check("t3_tmo", mdTimeout, 1'b0);

    // T4 branch beats mdStart
    mdStart = 1'b1; branchTaken = 1'b1; #1;
    check("t4_fl", fl_v, 3'b110);
    check("t4_wr", wr_v, 5'b11111);
    tick();
    mdStart = 1'b0; branchTaken = 1'b0; #1;
    check("t4_state", ctrlState, 2'd0);

    // T5 timeout after 8 MDWAIT cycles
    clear_stats();
    mdStart = 1'b1;
    tick();
    mdStart = 1'b0;
    for (int i = 0; i < 7; i++) begin
      #1;
      check("t5_wr_wait", wr_v, 5'b00011);
      check("t5_tmo_low", mdTimeout, 1'b0);
      tick();
    end
    #1;
    check("t5_state_rel", ctrlState, 2'd2);
    check("t5_wr_rel", wr_v, 5'b11111);
    tick();
    check("t5_state_run", ctrlState, 2'd0);
    check("t5_tmo_pulse", mdTimeout, 1'b1);
    check("t5_cnt", stallCycles, 4'd8);
    tick();
    check("t5_tmo_gone", mdTimeout, 1'b0);

    // T6 saturation, clear, reset mid-MDWAIT
    clear_stats();
    memReq = 1'b1; memReady = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("t6_state", ctrlState, 2'd1);
    check("t6_cnt_sat", stallCycles, 4'd15);
    statClr = 1'b1;
    tick();
    statClr = 1'b0;
    check("t6_cnt_clr", stallCycles, 4'd0);
    memReady = 1'b1;
    tick();
    memReq = 1'b0; memReady = 1'b0;
    mdStart = 1'b1;
    tick();
    mdStart = 1'b0;
    tick();
    check("t6_state_md", ctrlState, 2'd2);
    rst_n = 1'b0; #1;
    check("t6_rst_state", ctrlState, 2'd0);
    check("t6_rst_wr", wr_v, 5'b00000);
    check("t6_rst_cnt", stallCycles, 4'd0);
    tick();
    rst_n = 1'b1; #1;
    check("t6_post_wr", wr_v, 5'b11111);
    tick();
    check("t6_post_state", ctrlState, 2'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
